parking_lot_top: RTL and testbench

//  Top-level controller of a 7-floor automated parking lot with one car elevator at ground floor 0.

---
 rtl/parking_lot_top.sv | 396 +++++++++++++++++++++++++++++++++++++++
 tb/tb_parking_lot_top.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_top.sv
// -----------------------------------------------------------------------------
// parking_lot_top
//   Controller for a 7-floor automated parking lot. A single car elevator sits
//   at ground floor 0. Park and retrieve requests are queued in a small FIFO and
//   served one at a time by the elevator FSM. Each floor has two places. The
//   lower floors hold SUVs and the upper floors hold sedans.
//
// Ports
//   clock                  : rising-edge clock
//   reset                  : asynchronous, active-low; clears all state
//   license_plate [15:0]   : 4 BCD digits, [15:12] is the first digit
//   in_mode / out_mode     : one-cycle park / retrieve request pulses
//   leakage, leakage_floor : while leakage=1 that floor takes no new cars
//   parked_1..parked_7     : per floor {place1, place0}, 0 means empty
//   current_floor          : elevator floor 0..7
//   moving                 : plate currently inside the elevator
//   plate_type             : served plate is an SUV (first digit odd)
//   fee                    : fee of the last retrieved car
//   empty_suv/empty_sedan  : free slot counts; full_* when the count is 0
//   *_internal, target_*   : request being served and its destination
//   curr_state_for_test    : FSM state code
// -----------------------------------------------------------------------------
module parking_lot_top #(
  parameter int QDEPTH        = 8,
  parameter int SUV_TOP_FLOOR = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] license_plate,
  input  logic        in_mode,
  input  logic        out_mode,
  input  logic        leakage,
  input  logic [2:0]  leakage_floor,
  output logic [31:0] parked_1,
  output logic [31:0] parked_2,
  output logic [31:0] parked_3,
  output logic [31:0] parked_4,
  output logic [31:0] parked_5,
  output logic [31:0] parked_6,
  output logic [31:0] parked_7,
  output logic [2:0]  current_floor,
  output logic [15:0] moving,
  output logic        plate_type,
  output logic [7:0]  fee,
  output logic [3:0]  empty_suv,
  output logic [3:0]  empty_sedan,
  output logic        full_suv,
  output logic        full_sedan,
  output logic        in_mode_internal,
  output logic        out_mode_internal,
  output logic [15:0] license_plate_internal,
  output logic [2:0]  curr_state_for_test,
  output logic [2:0]  target_floor,
  output logic        target_place
);

  localparam int NSLOT  = 14;
  localparam int NSUV   = 2 * SUV_TOP_FLOOR;
  localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW     = $clog2(QDEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOAD  = 3'b001,
    S_UP    = 3'b010,
    S_STORE = 3'b011,
    S_DOWN  = 3'b100,
    S_FETCH = 3'b101,
    S_EXIT  = 3'b110
  } state_t;

  // FSM and request registers
  state_t      state_q, state_d;
  logic [2:0]  cur_floor_q, cur_floor_d;
  logic [15:0] moving_q, moving_d;
  logic [7:0]  fee_q, fee_d;
  logic        in_int_q, in_int_d;
  logic        out_int_q, out_int_d;
  logic [15:0] plate_int_q, plate_int_d;
  logic        type_q, type_d;
  logic [2:0]  tgt_floor_q, tgt_floor_d;
  logic        tgt_place_q, tgt_place_d;

  // Request FIFO
  logic [16:0]   fifo_mem [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  logic [16:0]   head;
  logic          head_park;
  logic [15:0]   head_plate;
  logic          head_suv;

  // Slot storage and search
  logic [15:0]      slot_plate [NSLOT];
  logic [7:0]       slot_timer [NSLOT];
  logic [NSLOT-1:0] slot_free;
  logic [NSLOT-1:0] slot_match;
  logic [NSLOT-1:0] slot_elig;
  logic [3:0]       tgt_idx;
  logic             slot_wr;
  logic             slot_clr;
  logic             alloc_ok;
  logic [3:0]       alloc_idx;
  logic             match_ok;
  logic [3:0]       match_idx;
  logic [7:0]       timer_sel;
  logic [7:0]       fee_calc;

  // Occupancy
  logic [3:0] free_suv, free_sedan;
  logic [3:0] empty_suv_q, empty_sedan_q;

  // ---------------------------------------------------------------------------
  // Request FIFO. A request is accepted only with exactly one mode bit set and
  // a non-zero plate. Fullness is judged on the count before this edge's pop.
  // ---------------------------------------------------------------------------
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push = (in_mode ^ out_mode) && (license_plate != 16'h0000) &&
                (count_q != CW'(QDEPTH));
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {in_mode, license_plate};
    end
  end

  assign head       = fifo_mem[rd_ptr_q];
  assign head_park  = head[16];
  assign head_plate = head[15:0];
  assign head_suv   = head_plate[12];

  // ---------------------------------------------------------------------------
  // Slots: slot index = (floor-1)*2 + place. Each slot owns a plate register
  // and a saturating dwell timer that sits at 0 whenever the slot is empty.
  // ---------------------------------------------------------------------------
  assign tgt_idx = {tgt_floor_q - 3'd1, tgt_place_q};

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      localparam int FL     = gi / 2 + 1;
      localparam bit IS_SUV = (FL <= SUV_TOP_FLOOR);
      logic [15:0] plate_q;
      logic [7:0]  timer_q;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          plate_q <= '0;
        end else if (slot_wr && (tgt_idx == 4'(gi))) begin
          plate_q <= plate_int_q;
        end else if (slot_clr && (tgt_idx == 4'(gi))) begin
          plate_q <= '0;
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          timer_q <= '0;
        end else if (plate_q == 16'h0000) begin
          timer_q <= '0;
        end else if (timer_q != 8'hFF) begin
          timer_q <= timer_q + 8'd1;
        end
      end

      assign slot_plate[gi] = plate_q;
      assign slot_timer[gi] = timer_q;
      assign slot_free[gi]  = (plate_q == 16'h0000);
      assign slot_match[gi] = (plate_q == head_plate);
      // A leaking floor takes no new cars, but existing ones stay retrievable.
      assign slot_elig[gi]  = slot_free[gi] && (IS_SUV == head_suv) &&
                              !(leakage && (leakage_floor == 3'(FL)));
    end
  endgenerate

  assign parked_1 = {slot_plate[1],  slot_plate[0]};
  assign parked_2 = {slot_plate[3],  slot_plate[2]};
  assign parked_3 = {slot_plate[5],  slot_plate[4]};
  assign parked_4 = {slot_plate[7],  slot_plate[6]};
  assign parked_5 = {slot_plate[9],  slot_plate[8]};
  assign parked_6 = {slot_plate[11], slot_plate[10]};
  assign parked_7 = {slot_plate[13], slot_plate[12]};

  // Scanning from the top down lets the lowest index win: lowest floor first,
  // place 0 before place 1.
  always_comb begin
    alloc_ok  = 1'b0;
    alloc_idx = '0;
    match_ok  = 1'b0;
    match_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (slot_elig[i]) begin
        alloc_ok  = 1'b1;
        alloc_idx = 4'(i);
      end
      if (slot_match[i]) begin
        match_ok  = 1'b1;
        match_idx = 4'(i);
      end
    end
  end

  always_comb begin
    timer_sel = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (tgt_idx == 4'(i)) begin
        timer_sel = slot_timer[i];
      end
    end
  end

  // SUVs pay double; the doubled value saturates at 255.
  assign fee_calc = type_q ? (timer_sel[7] ? 8'hFF : {timer_sel[6:0], 1'b0})
                           : timer_sel;

  // ---------------------------------------------------------------------------
  // Occupancy counts are registered from the slot contents, so they follow a
  // slot write by one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    free_suv   = '0;
    free_sedan = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (i < NSUV) begin
        free_suv = free_suv + {3'b000, slot_free[i]};
      end else begin
        free_sedan = free_sedan + {3'b000, slot_free[i]};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      empty_suv_q   <= 4'(NSUV);
      empty_sedan_q <= 4'(NSLOT - NSUV);
    end else begin
      empty_suv_q   <= free_suv;
      empty_sedan_q <= free_sedan;
    end
  end

  // ---------------------------------------------------------------------------
  // Elevator FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    moving_d    = moving_q;
    fee_d       = fee_q;
    in_int_d    = in_int_q;
    out_int_d   = out_int_q;
    plate_int_d = plate_int_q;
    type_d      = type_q;
    tgt_floor_d = tgt_floor_q;
    tgt_place_d = tgt_place_q;
    slot_wr     = 1'b0;
    slot_clr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Rejected requests are popped without being latched.
        if (count_q != '0) begin
          if (head_park) begin
            if (alloc_ok && !match_ok) begin
              in_int_d    = 1'b1;
              out_int_d   = 1'b0;
              plate_int_d = head_plate;
              type_d      = head_suv;
              tgt_floor_d = alloc_idx[3:1] + 3'd1;
              tgt_place_d = alloc_idx[0];
              state_d     = S_LOAD;
            end
          end else if (match_ok) begin
            in_int_d    = 1'b0;
            out_int_d   = 1'b1;
            plate_int_d = head_plate;
            type_d      = head_suv;
            tgt_floor_d = match_idx[3:1] + 3'd1;
            tgt_place_d = match_idx[0];
            state_d     = S_UP;
          end
        end
      end
      S_LOAD: begin
        moving_d = plate_int_q;
        state_d  = S_UP;
      end
      S_UP: begin
        if (cur_floor_q != tgt_floor_q) begin
          cur_floor_d = cur_floor_q + 3'd1;
        end else begin
          state_d = in_int_q ? S_STORE : S_FETCH;
        end
      end
      S_STORE: begin
        slot_wr  = 1'b1;
        moving_d = '0;
        state_d  = S_DOWN;
      end
      S_FETCH: begin
        slot_clr = 1'b1;
        moving_d = plate_int_q;
        fee_d    = fee_calc;
        state_d  = S_DOWN;
      end
      S_DOWN: begin
        if (cur_floor_q != 3'd0) begin
          cur_floor_d = cur_floor_q - 3'd1;
        end else if (in_int_q) begin
          state_d     = S_IDLE;
          in_int_d    = 1'b0;
          out_int_d   = 1'b0;
          plate_int_d = '0;
          type_d      = 1'b0;
          tgt_floor_d = '0;
          tgt_place_d = 1'b0;
        end else begin
          state_d = S_EXIT;
        end
      end
      S_EXIT: begin
        moving_d    = '0;
        state_d     = S_IDLE;
        in_int_d    = 1'b0;
        out_int_d   = 1'b0;
        plate_int_d = '0;
        type_d      = 1'b0;
        tgt_floor_d = '0;
        tgt_place_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cur_floor_q <= '0;
      moving_q    <= '0;
      fee_q       <= '0;
      in_int_q    <= 1'b0;
      out_int_q   <= 1'b0;
      plate_int_q <= '0;
      type_q      <= 1'b0;
      tgt_floor_q <= '0;
      tgt_place_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      moving_q    <= moving_d;
      fee_q       <= fee_d;
      in_int_q    <= in_int_d;
      out_int_q   <= out_int_d;
      plate_int_q <= plate_int_d;
      type_q      <= type_d;
      tgt_floor_q <= tgt_floor_d;
      tgt_place_q <= tgt_place_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign current_floor          = cur_floor_q;
  assign moving                 = moving_q;
  assign plate_type             = type_q;
  assign fee                    = fee_q;
  assign empty_suv              = empty_suv_q;
  assign empty_sedan            = empty_sedan_q;
  assign full_suv               = (empty_suv_q == 4'd0);
  assign full_sedan             = (empty_sedan_q == 4'd0);
  assign in_mode_internal       = in_int_q;
  assign out_mode_internal      = out_int_q;
  assign license_plate_internal = plate_int_q;
  assign curr_state_for_test    = state_q;
  assign target_floor           = tgt_floor_q;
  assign target_place           = tgt_place_q;

endmodule

// File: tb/tb_parking_lot_top.sv
// -----------------------------------------------------------------------------
// tb_parking_lot_top
//   Self-checking bench for parking_lot_top. A request-level reference model
//   (queue of requests, array of slots, trip schedule computed from the floor
//   number) predicts every output each cycle. Directed table vectors and a
//   few hand sequences cover the named scenarios; a random phase follows.
// -----------------------------------------------------------------------------
module tb_parking_lot_top;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] license_plate;
  logic        in_mode, out_mode, leakage;
  logic [2:0]  leakage_floor;
  logic [31:0] parked_1, parked_2, parked_3, parked_4, parked_5, parked_6, parked_7;
  logic [2:0]  current_floor;
  logic [15:0] moving;
  logic        plate_type;
  logic [7:0]  fee;
  logic [3:0]  empty_suv, empty_sedan;
  logic        full_suv, full_sedan;
  logic        in_mode_internal, out_mode_internal;
  logic [15:0] license_plate_internal;
  logic [2:0]  curr_state_for_test, target_floor;
  logic        target_place;

  parking_lot_top dut (
    .clock(clock), .reset(reset), .license_plate(license_plate),
    .in_mode(in_mode), .out_mode(out_mode), .leakage(leakage),
    .leakage_floor(leakage_floor),
    .parked_1(parked_1), .parked_2(parked_2), .parked_3(parked_3),
    .parked_4(parked_4), .parked_5(parked_5), .parked_6(parked_6),
    .parked_7(parked_7), .current_floor(current_floor), .moving(moving),
    .plate_type(plate_type), .fee(fee), .empty_suv(empty_suv),
    .empty_sedan(empty_sedan), .full_suv(full_suv), .full_sedan(full_sedan),
    .in_mode_internal(in_mode_internal), .out_mode_internal(out_mode_internal),
    .license_plate_internal(license_plate_internal),
    .curr_state_for_test(curr_state_for_test), .target_floor(target_floor),
    .target_place(target_place)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  typedef struct {
    bit          park;
    logic [15:0] plate;
  } req_t;

  req_t        mq[$];
  logic [15:0] mslot [14];
  int          mstore [14];
  bit          mbusy;
  int          mt0, mf, mp;
  bit          mpark, msuv;
  logic [15:0] mplate;
  int          n;
  logic [7:0]  mfee;
  int          mempty_suv, mempty_sedan;
  int          prev_floor;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 60)
        $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 14; i++) begin
      mslot[i]  = '0;
      mstore[i] = 0;
    end
    mbusy = 0; mt0 = 0; mf = 0; mp = 0; mpark = 0; msuv = 0; mplate = '0;
    n = 0; mfee = '0; mempty_suv = 6; mempty_sedan = 8;
  endtask

  task automatic serve(input req_t r);
    bit found;
    int fl, pl;
    found = 0; fl = 0; pl = 0;
    for (int i = 0; i < 14; i++)
      if (mslot[i] == r.plate) begin found = 1; fl = i / 2 + 1; pl = i % 2; end
    if (r.park) begin
      if (found) begin
        $display("[TB] edge %0d: park %04h dropped (already parked)", n, r.plate);
        return;
      end
      for (int f = 1; f <= 7; f++)
        for (int p = 0; p < 2; p++)
          if (!found && !(leakage && leakage_floor == f) &&
              ((f <= 3) == r.plate[12]) && mslot[(f-1)*2+p] == 16'h0) begin
            found = 1; fl = f; pl = p;
          end
      if (!found) begin
        $display("[TB] edge %0d: park %04h dropped (no slot)", n, r.plate);
        return;
      end
    end else if (!found) begin
      $display("[TB] edge %0d: retrieve %04h dropped (not parked)", n, r.plate);
      return;
    end
    mbusy = 1; mt0 = n; mf = fl; mp = pl; mpark = r.park; mplate = r.plate;
    msuv = r.plate[12];
    $display("[TB] edge %0d: %s %04h -> floor %0d place %0d", n,
             r.park ? "park" : "retrieve", r.plate, fl, pl);
  endtask

  // Predicts the effect of the coming rising edge with the inputs now driven.
  task automatic model_edge();
    int es, ed, qs, k, idx, raw;
    req_t r;
    n++;
    qs = mq.size();
    es = 0; ed = 0;
    for (int i = 0; i < 14; i++)
      if (mslot[i] == 16'h0) begin
        if (i < 6) es++; else ed++;
      end
    if (mbusy) begin
      k = n - mt0;
      idx = (mf - 1) * 2 + mp;
      if (mpark && k == mf + 3) begin
        mslot[idx] = mplate; mstore[idx] = n;
      end
      if (!mpark && k == mf + 2) begin
        raw = n - mstore[idx] - 1;
        if (raw > 255) raw = 255;
        if (msuv) raw = raw * 2;
        if (raw > 255) raw = 255;
        mfee = 8'(raw);
        mslot[idx] = '0;
      end
      if (k == 2 * mf + 4) mbusy = 0;
    end else if (qs > 0) begin
      r = mq.pop_front();
      serve(r);
    end
    if ((in_mode ^ out_mode) && license_plate != 16'h0 && qs < 8) begin
      r.park = in_mode; r.plate = license_plate;
      mq.push_back(r);
    end
    mempty_suv = es; mempty_sedan = ed;
  endtask

  function automatic logic [31:0] parked_of(input int fl);
    case (fl)
      1: return parked_1;
      2: return parked_2;
      3: return parked_3;
      4: return parked_4;
      5: return parked_5;
      6: return parked_6;
      7: return parked_7;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_cycle();
    int k, ef, diff;
    logic [2:0] est;
    logic [15:0] emv;
    ef = 0; est = 3'd0; emv = '0;
    if (mbusy) begin
      k = n - mt0;
      if (mpark) begin
        if (k <= 1) ef = 0; else if (k <= mf + 1) ef = k - 1;
        else if (k <= mf + 3) ef = mf; else if (k <= 2*mf + 3) ef = 2*mf + 3 - k;
        if (k == 0) est = 3'd1; else if (k <= mf + 1) est = 3'd2;
        else if (k == mf + 2) est = 3'd3; else est = 3'd4;
        if (k >= 1 && k <= mf + 2) emv = mplate;
      end else begin
        if (k <= mf) ef = k; else if (k <= mf + 2) ef = mf;
        else if (k <= 2*mf + 2) ef = 2*mf + 2 - k;
        if (k <= mf) est = 3'd2; else if (k == mf + 1) est = 3'd5;
        else if (k <= 2*mf + 2) est = 3'd4; else est = 3'd6;
        if (k >= mf + 2) emv = mplate;
      end
    end
    cmp("current_floor", 32'(current_floor), 32'(ef));
    cmp("state", 32'(curr_state_for_test), 32'(est));
    cmp("moving", 32'(moving), 32'(emv));
    cmp("fee", 32'(fee), 32'(mfee));
    cmp("empty_suv", 32'(empty_suv), 32'(mempty_suv));
    cmp("empty_sedan", 32'(empty_sedan), 32'(mempty_sedan));
    cmp("full_suv", 32'(full_suv), 32'(mempty_suv == 0));
    cmp("full_sedan", 32'(full_sedan), 32'(mempty_sedan == 0));
    cmp("in_mode_internal", 32'(in_mode_internal), 32'(mbusy && mpark));
    cmp("out_mode_internal", 32'(out_mode_internal), 32'(mbusy && !mpark));
    cmp("plate_internal", 32'(license_plate_internal), mbusy ? 32'(mplate) : 32'h0);
    cmp("plate_type", 32'(plate_type), 32'(mbusy && msuv));
    cmp("target_floor", 32'(target_floor), mbusy ? 32'(mf) : 32'h0);
    cmp("target_place", 32'(target_place), mbusy ? 32'(mp) : 32'h0);
    for (int f = 1; f <= 7; f++)
      cmp($sformatf("parked_%0d", f), parked_of(f), {mslot[2*f-1], mslot[2*f-2]});
    if (prev_floor >= 0) begin
      diff = int'(current_floor) - prev_floor;
      cmp("floor_step", 32'(diff <= 1 && diff >= -1), 32'h1);
    end
    prev_floor = int'(current_floor);
  endtask

  // ---------------- stimulus helpers (called just after a falling edge) ----
  task automatic cyc(input bit im, input bit om, input logic [15:0] pl);
    in_mode = im; out_mode = om; license_plate = pl;
    model_edge();
    @(negedge clock);
    check_cycle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_mode = 0; out_mode = 0; license_plate = '0;
    model_reset();
    prev_floor = -1;
    #1;
    check_cycle();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    check_cycle();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((mbusy || mq.size() > 0) && guard < 600) begin
      cyc(0, 0, 16'h0);
      guard++;
    end
    cmp("drain_timeout", 32'(guard < 600), 32'h1);
    cyc(0, 0, 16'h0);
    cyc(0, 0, 16'h0);
  endtask

  typedef struct {
    logic [15:0] plate;
    int          fl;
    int          pl;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] pool[12];
  logic [15:0] half;
  int          cnt, r;
  logic [15:0] rp;

  initial begin
    reset = 1'b0; in_mode = 0; out_mode = 0; license_plate = '0;
    leakage = 0; leakage_floor = 3'd0;
    prev_floor = -1;
    model_reset();
    @(negedge clock);
    do_reset();
    cmp("rst_floor", 32'(current_floor), 32'h0);
    cmp("rst_empty_suv", 32'(empty_suv), 32'd6);
    cmp("rst_empty_sedan", 32'(empty_sedan), 32'd8);
    cmp("rst_state", 32'(curr_state_for_test), 32'h0);

    // single park of 9423
    cyc(1, 0, 16'h9423);
    cyc(0, 0, 16'h0);
    cmp("p1_state_load", 32'(curr_state_for_test), 32'd1);
    cmp("p1_target_floor", 32'(target_floor), 32'd1);
    cmp("p1_target_place", 32'(target_place), 32'd0);
    cyc(0, 0, 16'h0);
    cmp("p1_moving", 32'(moving), 32'h9423);
    drain();
    cmp("p1_slot", parked_1, 32'h0000_9423);
    cmp("p1_empty_suv", 32'(empty_suv), 32'd5);
    cmp("p1_moving_done", 32'(moving), 32'h0);

    // table: back-to-back pulses two cycles apart, then a duplicate park
    do_reset();
    vecs[0] = '{16'h9423, 1, 0};
    vecs[1] = '{16'h8754, 4, 0};
    vecs[2] = '{16'h3891, 1, 1};
    vecs[3] = '{16'h7956, 2, 0};
    vecs[4] = '{16'h9706, 2, 1};
    vecs[5] = '{16'h2666, 4, 1};
    vecs[6] = '{16'h9423, 1, 0};
    for (int i = 0; i < 7; i++) begin
      cyc(1, 0, vecs[i].plate);
      cyc(0, 0, 16'h0);
    end
    drain();
    for (int i = 0; i < 7; i++) begin
      half = vecs[i].pl ? parked_of(vecs[i].fl)[31:16] : parked_of(vecs[i].fl)[15:0];
      cmp($sformatf("table_slot_%0d", i), 32'(half), 32'(vecs[i].plate));
      cnt = 0;
      for (int f = 1; f <= 7; f++) begin
        if (parked_of(f)[15:0] == vecs[i].plate) cnt++;
        if (parked_of(f)[31:16] == vecs[i].plate) cnt++;
      end
      cmp($sformatf("table_unique_%0d", i), 32'(cnt), 32'd1);
      $display("[TB] table %0d: plate %04h expected floor %0d place %0d", i,
               vecs[i].plate, vecs[i].fl, vecs[i].pl);
    end
    cmp("table_empty_suv", 32'(empty_suv), 32'd2);
    cmp("table_empty_sedan", 32'(empty_sedan), 32'd6);

    // retrieve 3891
    for (int i = 0; i < 20; i++) cyc(0, 0, 16'h0);
    cyc(0, 1, 16'h3891);
    drain();
    cmp("ret_slot_clear", 32'(parked_1[31:16]), 32'h0);
    cmp("ret_fee_even", 32'(fee[0]), 32'h0);
    cmp("ret_fee_nonzero", 32'(fee != 8'h0), 32'h1);

    // leakage on floor 1, then unknown retrieve
    do_reset();
    leakage = 1; leakage_floor = 3'd1;
    cyc(1, 0, 16'h7956);
    drain();
    cmp("leak_floor2", parked_2, 32'h0000_7956);
    cmp("leak_floor1", parked_1, 32'h0);
    cyc(0, 1, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 16'h0);
      cmp("unknown_idle", 32'(curr_state_for_test), 32'h0);
    end
    leakage = 0; leakage_floor = 3'd0;

    // reset in the middle of a trip with cars parked
    cyc(1, 0, 16'h2666);
    for (int i = 0; i < 6; i++) cyc(0, 0, 16'h0);
    do_reset();
    cmp("midrst_floor", 32'(current_floor), 32'h0);
    cmp("midrst_moving", 32'(moving), 32'h0);
    cmp("midrst_p2", parked_2, 32'h0);
    cmp("midrst_empty_suv", 32'(empty_suv), 32'd6);

    // random phase
    for (int i = 0; i < 12; i++)
      pool[i] = {4'($urandom_range(1, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        leakage = ~leakage;
        leakage_floor = 3'($urandom_range(0, 7));
      end
      rp = pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 29) == 0) rp = 16'h0;
      r = $urandom_range(0, 99);
      if (r < 12) cyc(1, 0, rp);
      else if (r < 22) cyc(0, 1, rp);
      else if (r < 24) cyc(1, 1, rp);
      else cyc(0, 0, rp);
      if (c == 1500) do_reset();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
